// File: rtl/banked_spfifo_if.sv
// Handshake and status bundle for banked_spfifo.
// master drives requests and data; slave is the FIFO.
interface banked_spfifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             push;
    logic [WIDTH-1:0] wdata;
    logic             pop;
    logic [WIDTH-1:0] rdata;
    logic             valid;
    logic             ack;
    logic             full;
    logic             empty;
    logic             al_full;
    logic             al_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, push, wdata, pop,
        input  rdata, valid, ack, full, empty,
        input  al_full, al_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  flush, push, wdata, pop,
        output rdata, valid, ack, full, empty,
        output al_full, al_empty, count,
        output overflow, underflow
    );
endinterface

// File: rtl/banked_spfifo.sv
// FIFO over interleaved single-port RAM banks; a per-bank hold register
// absorbs a write that collides with a read of the same bank.
module banked_spfifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int BANKS    = 2,
    parameter int AL_FULL  = 2,
    parameter int AL_EMPTY = 2
) (
    input logic            clk,
    input logic            rst,
    banked_spfifo_if.slave f
);
    localparam int AW   = $clog2(DEPTH);
    localparam int BW   = $clog2(BANKS);
    localparam int RW   = AW - BW;
    localparam int ROWS = DEPTH / BANKS;
    localparam int CW   = AW + 1;

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic [BW-1:0]    rd_bank_q, rd_bank_d;
    logic [BANKS-1:0] hold_occ_q, hold_occ_d;
    logic [RW-1:0]    hold_row_q [BANKS];
    logic [RW-1:0]    hold_row_d [BANKS];
    logic [WIDTH-1:0] hold_data_q [BANKS];
    logic [WIDTH-1:0] hold_data_d [BANKS];

    logic [BANKS-1:0] rd_hit, wr_hit, ram_we;
    logic [RW-1:0]    ram_row [BANKS];
    logic [WIDTH-1:0] ram_wd [BANKS];
    logic [WIDTH-1:0] bank_rd [BANKS];

    logic             clr, full_w, empty_w, wen, ren;
    logic [BW-1:0]    wbank, rbank;
    logic [RW-1:0]    wrow, rrow;

    always_comb begin
        clr     = rst | f.flush;
        full_w  = (count_q == CW'(DEPTH));
        empty_w = (count_q == '0);
        wen     = f.push & ~full_w & ~clr;
        ren     = f.pop & ~empty_w & ~clr;
        wbank   = wr_ptr_q[BW-1:0];
        wrow    = wr_ptr_q[AW-1:BW];
        rbank   = rd_ptr_q[BW-1:0];
        rrow    = rd_ptr_q[AW-1:BW];

        wr_ptr_d  = clr ? '0 : wr_ptr_q + CW'(wen);
        rd_ptr_d  = clr ? '0 : rd_ptr_q + CW'(ren);
        count_d   = clr ? '0 : count_q + CW'(wen) - CW'(ren);
        valid_d   = ren;
        rd_bank_d = ren ? rbank : rd_bank_q;

        for (int b = 0; b < BANKS; b++) begin
            rd_hit[b]      = ren && (rbank == BW'(b));
            wr_hit[b]      = wen && (wbank == BW'(b));
            hold_occ_d[b]  = hold_occ_q[b];
            hold_row_d[b]  = hold_row_q[b];
            hold_data_d[b] = hold_data_q[b];
            ram_we[b]      = 1'b0;
            ram_row[b]     = wrow;
            ram_wd[b]      = f.wdata;
            // Read owns the port; a colliding write parks in the hold slot.
            if (clr) begin
                hold_occ_d[b] = 1'b0;
            end else if (rd_hit[b]) begin
                if (wr_hit[b]) begin
                    hold_occ_d[b]  = 1'b1;
                    hold_row_d[b]  = wrow;
                    hold_data_d[b] = f.wdata;
                end
            end else if (wr_hit[b]) begin
                ram_we[b] = 1'b1;
            end else if (hold_occ_q[b]) begin
                ram_we[b]     = 1'b1;
                ram_row[b]    = hold_row_q[b];
                ram_wd[b]     = hold_data_q[b];
                hold_occ_d[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            rd_bank_q  <= '0;
            hold_occ_q <= '0;
            for (int b = 0; b < BANKS; b++) begin
                hold_row_q[b]  <= '0;
                hold_data_q[b] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            rd_bank_q  <= rd_bank_d;
            hold_occ_q <= hold_occ_d;
            for (int b = 0; b < BANKS; b++) begin
                hold_row_q[b]  <= hold_row_d[b];
                hold_data_q[b] <= hold_data_d[b];
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem [ROWS];
        logic [WIDTH-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (ram_we[b]) mem[ram_row[b]] <= ram_wd[b];
            if (rd_hit[b]) rd_q <= mem[rrow];
        end

        assign bank_rd[b] = rd_q;

        a_no_wr_over_hold: assert property (
            @(posedge clk) disable iff (rst)
            !(wr_hit[b] && hold_occ_q[b]));
        a_no_rd_of_held_row: assert property (
            @(posedge clk) disable iff (rst)
            !(rd_hit[b] && hold_occ_q[b] && hold_row_q[b] == rrow));
    end

    assign f.rdata     = valid_q ? bank_rd[rd_bank_q] : '0;
    assign f.valid     = valid_q;
    assign f.ack       = wen;
    assign f.full      = full_w;
    assign f.empty     = empty_w;
    assign f.count     = count_q;
    assign f.overflow  = f.push & full_w & ~clr;
    assign f.underflow = f.pop & empty_w & ~clr;
    assign f.al_full   = (AL_FULL != 0) &&
                         ((CW'(DEPTH) - count_q) <= CW'(AL_FULL));
    assign f.al_empty  = (AL_EMPTY != 0) && (count_q <= CW'(AL_EMPTY));
endmodule

// File: tb/tb_banked_spfifo.sv
// Scoreboard bench for banked_spfifo: a 2-bank/32-deep instance on
// directed corner cases and a 4-bank/16-deep instance on a mixed stream.
module tb_banked_spfifo;
    localparam int W  = 16;
    localparam int D  = 32;
    localparam int D4 = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    banked_spfifo_if #(.WIDTH(W), .DEPTH(D))  f ();
    banked_spfifo_if #(.WIDTH(W), .DEPTH(D4)) f4 ();

    banked_spfifo #(
        .WIDTH(W), .DEPTH(D), .BANKS(2), .AL_FULL(2), .AL_EMPTY(2)
    ) dut (.clk(clk), .rst(rst), .f(f));

    banked_spfifo #(
        .WIDTH(W), .DEPTH(D4), .BANKS(4), .AL_FULL(2), .AL_EMPTY(2)
    ) dut4 (.clk(clk), .rst(rst), .f(f4));

    int checks = 0;
    int errors = 0;
    int pushes4 = 0;

    logic [W-1:0] model[$];
    logic [W-1:0] model4[$];
    logic [W:0]   exp_q[$];
    logic [W:0]   exp4[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per driven cycle, checked after the edge.
    always @(posedge clk) begin : mon
        logic [W:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid", int'(f.valid), int'(e[W]));
            chk("rdata", int'(f.rdata), int'(e[W-1:0]));
        end
        if (exp4.size() > 0) begin
            e = exp4.pop_front();
            chk("valid4", int'(f4.valid), int'(e[W]));
            chk("rdata4", int'(f4.rdata), int'(e[W-1:0]));
        end
    end

    task automatic step(input logic p, input logic [W-1:0] d,
                        input logic q, input logic fl, input logic r);
        int n;
        logic live, wen, ren;
        logic [W-1:0] hd;
        @(negedge clk);
        rst = r; f.flush = fl; f.push = p; f.wdata = d; f.pop = q;
        #1;
        n    = model.size();
        live = !r && !fl;
        wen  = live && p && (n < D);
        ren  = live && q && (n > 0);
        chk("ack", int'(f.ack), int'(wen));
        chk("overflow", int'(f.overflow), int'(live && p && n == D));
        chk("underflow", int'(f.underflow), int'(live && q && n == 0));
        chk("count", int'(f.count), n);
        chk("full", int'(f.full), int'(n == D));
        chk("empty", int'(f.empty), int'(n == 0));
        chk("al_full", int'(f.al_full), int'(D - n <= 2));
        chk("al_empty", int'(f.al_empty), int'(n <= 2));
        if (!live) begin
            model.delete();
            exp_q.push_back('0);
        end else begin
            if (ren) begin
                hd = model.pop_front();
                exp_q.push_back({1'b1, hd});
            end else begin
                exp_q.push_back('0);
            end
            if (wen) model.push_back(d);
        end
    endtask

    task automatic step4(input logic p, input logic [W-1:0] d, input logic q);
        int n;
        logic wen, ren;
        logic [W-1:0] hd;
        @(negedge clk);
        rst = 1'b0; f4.flush = 1'b0;
        f4.push = p; f4.wdata = d; f4.pop = q;
        #1;
        n   = model4.size();
        wen = p && (n < D4);
        ren = q && (n > 0);
        chk("ack4", int'(f4.ack), int'(wen));
        chk("count4", int'(f4.count), n);
        chk("full4", int'(f4.full), int'(n == D4));
        chk("empty4", int'(f4.empty), int'(n == 0));
        chk("al_full4", int'(f4.al_full), int'(D4 - n <= 2));
        chk("al_empty4", int'(f4.al_empty), int'(n <= 2));
        if (ren) begin
            hd = model4.pop_front();
            exp4.push_back({1'b1, hd});
        end else begin
            exp4.push_back('0);
        end
        if (wen) begin
            model4.push_back(d);
            pushes4++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        f.flush = 1'b0; f.push = 1'b0; f.pop = 1'b0; f.wdata = '0;
        f4.flush = 1'b0; f4.push = 1'b0; f4.pop = 1'b0; f4.wdata = '0;
        repeat (2) @(negedge clk);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Fill to full, then overflow alone and with a concurrent pop.
        for (int i = 1; i <= D; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0021, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b1, 1'b0, 1'b0);

        // Drain back-to-back, underflow, then push+pop on empty.
        for (int i = 0; i < D - 1; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);

        // Occupancy 4, then sustained same-bank push+pop collisions.
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h60 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++)
            step(1'b1, 16'(16'h100 + i), 1'b1, 1'b0, 1'b0);

        // Occupancy 10, flush with push and pop, then reuse.
        for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h200 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Pop in flight, then pop with reset asserted.
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h300 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        f.push = 1'b0; f.pop = 1'b0;

        // 4-bank instance: deterministic mixed push/pop stream.
        for (int i = 0; i < 800; i++)
            step4(((i * 13) % 17) < 9, 16'(i * 37 + 5), ((i * 11) % 19) < 10);
        @(negedge clk);
        f4.push = 1'b0; f4.pop = 1'b0;
        chk("wraps4", int'(pushes4 >= 10 * D4), 1);

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size() + exp4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
